// File: rtl/pipe_pkg.sv
// Shared PIPE definitions: PowerDown codes, RxStatus codes, FSM state encodings
// and a small helper used to size the shared delay counter.
package pipe_pkg;

  localparam logic [3:0] P0  = 4'd0;
  localparam logic [3:0] P0S = 4'd1;
  localparam logic [3:0] P1  = 4'd2;
  localparam logic [3:0] P2  = 4'd3;

  localparam logic [2:0] RXSTAT_DETECTED = 3'b011;

  typedef enum logic [2:0] {
    RST_ACK     = 3'd0,
    IDLE        = 3'd1,
    DETECT      = 3'd2,
    DETECT_WAIT = 3'd3,
    PD_CHANGE   = 3'd4,
    RATE_CHANGE = 3'd5
  } pipeState_e;

  function automatic int maxOf3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pipe_delay_counter.sv
// Down-counter shared by all timed states: load with latency-1, count to zero,
// hold at zero (no wrap-around).
module pipe_delay_counter #(
  parameter int WIDTH = 4
) (
  input  logic             pclk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] loadValue,
  input  logic             dec,
  output logic [WIDTH-1:0] count,
  output logic             zero
);

  // Load has priority over decrement; decrement saturates at zero.
  always_ff @(posedge pclk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= loadValue;
    end else if (dec && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/pipe_phy_responder.sv
// PHY-side responder for the PIPE command/status interface.
// Optional rate-change handshake is built when PIPE_RATE_CHANGE_EN is defined.
//
//   state       | meaning
//   ------------+-----------------------------------------------------------
//   RST_ACK     | PhyStatus held high from reset, dropped on first cycle out
//   IDLE        | waiting for detect / PowerDown change / rate change
//   DETECT      | receiver-detect timer running, pulse on its last cycle
//   DETECT_WAIT | response given, waiting for lane-0 request to drop
//   PD_CHANGE   | PowerDown transition timer running, pulse on its last cycle
//   RATE_CHANGE | rate transition timer running, pulse on its last cycle
module pipe_phy_responder
  import pipe_pkg::*;
#(
  parameter int                     LANESNUMBER    = 16,
  parameter int                     DETECT_LATENCY = 4,
  parameter int                     PD_LATENCY     = 2,
  parameter int                     RATE_LATENCY   = 8,
  parameter logic [LANESNUMBER-1:0] CONNECTED_MASK = 16'hFFFF
) (
  input  logic                       pclk,
  input  logic                       reset,
  input  logic [LANESNUMBER-1:0]     TxDetectRx_Loopback,
  input  logic [LANESNUMBER-1:0]     TxElecIdle,
  input  logic [4*LANESNUMBER-1:0]   PowerDown,
  input  logic [3:0]                 Rate,
  output logic [LANESNUMBER-1:0]     PhyStatus,
  output logic [3*LANESNUMBER-1:0]   RxStatus,
  output logic [LANESNUMBER-1:0]     RxElectricalIdle,
  output logic                       busy
);

  localparam int CNT_W = $clog2(maxOf3(DETECT_LATENCY, PD_LATENCY, RATE_LATENCY)) + 1;

  pipeState_e              state;
  logic [3:0]              pdLatched;
  logic [3:0]              rateLatched;
  logic                    detectReq;
  logic                    pdChange;
  logic                    rateChange;
  logic                    cntLoad;
  logic [CNT_W-1:0]        cntLoadValue;
  logic                    cntDec;
  logic [CNT_W-1:0]        cntCount;
  logic                    cntZero;
  logic                    cntOne;
  logic [3*LANESNUMBER-1:0] detectStatus;
  logic [LANESNUMBER-1:0]  rxEiNext;
  logic                    unusedCtrl;

  // Only lane 0 steers control; the remaining lanes and (optionally) Rate are unused.
  assign unusedCtrl = ^{TxDetectRx_Loopback, PowerDown, Rate};

  assign detectReq = TxDetectRx_Loopback[0] && TxElecIdle[0] && (PowerDown[3:0] == P1);
  assign pdChange  = (PowerDown[3:0] != pdLatched);
`ifdef PIPE_RATE_CHANGE_EN
  assign rateChange = (Rate != rateLatched);
`else
  assign rateChange = 1'b0;
`endif
  assign cntOne = (cntCount == CNT_W'(1));

  // Counter load on IDLE exit follows the same priority as the FSM.
  always_comb begin
    cntLoad      = 1'b0;
    cntLoadValue = '0;
    if (state == IDLE) begin
      if (detectReq) begin
        cntLoad      = 1'b1;
        cntLoadValue = CNT_W'(DETECT_LATENCY - 1);
      end else if (pdChange) begin
        cntLoad      = 1'b1;
        cntLoadValue = CNT_W'(PD_LATENCY - 1);
      end else if (rateChange) begin
        cntLoad      = 1'b1;
        cntLoadValue = CNT_W'(RATE_LATENCY - 1);
      end
    end
    cntDec = (state == DETECT) || (state == PD_CHANGE) || (state == RATE_CHANGE);
  end

  pipe_delay_counter #(.WIDTH(CNT_W)) uDelay (
    .pclk      (pclk),
    .reset     (reset),
    .load      (cntLoad),
    .loadValue (cntLoadValue),
    .dec       (cntDec),
    .count     (cntCount),
    .zero      (cntZero)
  );

  // Per-lane detect result presented on the pulse cycle.
  always_comb begin
    detectStatus = '0;
    for (int i = 0; i < LANESNUMBER; i++) begin
      if (CONNECTED_MASK[i]) detectStatus[3*i +: 3] = RXSTAT_DETECTED;
    end
  end

  // Main handshake FSM; PhyStatus/RxStatus/busy are registered alongside the state.
  always_ff @(posedge pclk) begin
    if (reset) begin
      state       <= RST_ACK;
      PhyStatus   <= '1;
      RxStatus    <= '0;
      busy        <= 1'b1;
      pdLatched   <= P1;
      rateLatched <= '0;
    end else begin
      PhyStatus <= '0;
      RxStatus  <= '0;
      case (state)
        RST_ACK: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        IDLE: begin
          if (detectReq) begin
            state <= DETECT;
            busy  <= 1'b1;
            if (DETECT_LATENCY == 1) begin
              PhyStatus <= '1;
              RxStatus  <= detectStatus;
            end
          end else if (pdChange) begin
            state     <= PD_CHANGE;
            busy      <= 1'b1;
            pdLatched <= PowerDown[3:0];
            if (PD_LATENCY == 1) PhyStatus <= '1;
          end else if (rateChange) begin
            state       <= RATE_CHANGE;
            busy        <= 1'b1;
            rateLatched <= Rate;
            if (RATE_LATENCY == 1) PhyStatus <= '1;
          end
        end
        DETECT: begin
          if (cntZero) begin
            state <= DETECT_WAIT;
          end else if (cntOne) begin
            PhyStatus <= '1;
            RxStatus  <= detectStatus;
          end
        end
        DETECT_WAIT: begin
          if (!TxDetectRx_Loopback[0]) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        PD_CHANGE, RATE_CHANGE: begin
          if (cntZero) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (cntOne) begin
            PhyStatus <= '1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Receiver electrical idle: active lanes only in P0 with the transmitter running.
  always_comb begin
    rxEiNext = '1;
    for (int i = 0; i < LANESNUMBER; i++) begin
      if ((pdLatched == P0) && CONNECTED_MASK[i] && !TxElecIdle[i]) rxEiNext[i] = 1'b0;
    end
`ifdef PIPE_RATE_CHANGE_EN
    if (state == RATE_CHANGE) rxEiNext = '1;
`endif
  end

  // Register the electrical-idle outputs.
  always_ff @(posedge pclk) begin
    if (reset) RxElectricalIdle <= '1;
    else       RxElectricalIdle <= rxEiNext;
  end

endmodule

// File: tb/tb_pipe_phy_responder.sv
// Directed bench for pipe_phy_responder: two instances (all lanes connected,
// and lanes 0-7 only) share stimulus; a negedge monitor pops expected pulses.
module tb_pipe_phy_responder;
  import pipe_pkg::*;

  typedef struct {
    int          cycle;
    logic [47:0] rx;
    logic [47:0] rxM;
  } pulseExp_t;

  logic        pclk = 1'b0;
  logic        reset;
  logic [15:0] txDetect;
  logic [15:0] txElecIdle;
  logic [63:0] powerDown;
  logic [3:0]  rate;
  logic [15:0] phyStatus, phyStatusM;
  logic [47:0] rxStatus, rxStatusM;
  logic [15:0] rxEi, rxEiM;
  logic        busy, busyM;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int c;
  bit monOn = 1'b0;
  pulseExp_t expQ[$];
  pulseExp_t e;
  logic [47:0] detAll, detLow;

  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc <= cyc + 1;

  pipe_phy_responder dut (
    .pclk(pclk), .reset(reset), .TxDetectRx_Loopback(txDetect), .TxElecIdle(txElecIdle),
    .PowerDown(powerDown), .Rate(rate), .PhyStatus(phyStatus), .RxStatus(rxStatus),
    .RxElectricalIdle(rxEi), .busy(busy)
  );

  pipe_phy_responder #(.CONNECTED_MASK(16'h00FF)) dutMask (
    .pclk(pclk), .reset(reset), .TxDetectRx_Loopback(txDetect), .TxElecIdle(txElecIdle),
    .PowerDown(powerDown), .Rate(rate), .PhyStatus(phyStatusM), .RxStatus(rxStatusM),
    .RxElectricalIdle(rxEiM), .busy(busyM)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic waitN(input int n);
    repeat (n) @(negedge pclk);
  endtask

  function automatic logic [47:0] detExp(input logic [15:0] mask);
    logic [47:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) if (mask[i]) r[3*i +: 3] = 3'b011;
    return r;
  endfunction

  function automatic logic [63:0] allLanes(input logic [3:0] code);
    return {16{code}};
  endfunction

  task automatic pushExp(input int cy, input logic [47:0] rx, input logic [47:0] rxM);
    pulseExp_t p;
    p.cycle = cy;
    p.rx    = rx;
    p.rxM   = rxM;
    expQ.push_back(p);
  endtask

  // Scoreboard side: every PhyStatus pulse must match the next expected entry.
  always @(negedge pclk) begin
    if (monOn) begin
      if (phyStatus !== 16'h0000) begin
        chk("pulse_all_lanes", phyStatus, 16'hFFFF);
        chk("pulse_masked_inst", phyStatusM, 16'hFFFF);
        chk("pulse_expected", expQ.size() != 0, 1);
        if (expQ.size() != 0) begin
          e = expQ.pop_front();
          chk("pulse_cycle", cyc, e.cycle);
          chk("pulse_rxstatus", rxStatus, e.rx);
          chk("pulse_rxstatus_masked", rxStatusM, e.rxM);
        end
      end else begin
        chk("no_pulse_masked_inst", phyStatusM, 16'h0000);
        chk("rxstatus_quiet", rxStatus, 48'h0);
        chk("rxstatus_quiet_masked", rxStatusM, 48'h0);
      end
    end
  end

  initial begin
    detAll     = detExp(16'hFFFF);
    detLow     = detExp(16'h00FF);
    reset      = 1'b1;
    txDetect   = '0;
    txElecIdle = '1;
    powerDown  = allLanes(P1);
    rate       = 4'd0;

    // Reset values and release
    waitN(3);
    chk("rst_phystatus", phyStatus, 16'hFFFF);
    chk("rst_rxstatus", rxStatus, 48'h0);
    chk("rst_rxei", rxEi, 16'hFFFF);
    chk("rst_busy", busy, 1'b1);
    reset = 1'b0;
    waitN(1);
    chk("rstack_phystatus", phyStatus, 16'h0000);
    chk("rstack_busy", busy, 1'b0);
    chk("rstack_busy_masked", busyM, 1'b0);
    monOn = 1'b1;

    // Receiver detect in P1, request held well past the response
    c = cyc;
    txDetect = 16'hFFFF;
    pushExp(c + 4, detAll, detLow);
    waitN(8);
    chk("detect_served", expQ.size(), 0);
    chk("busy_detect_wait", busy, 1'b1);
    txDetect = '0;
    waitN(2);
    chk("busy_after_detect", busy, 1'b0);

    // PowerDown P1 -> P0 with transmitters active
    c = cyc;
    powerDown  = allLanes(P0);
    txElecIdle = '0;
    pushExp(c + 2, 48'h0, 48'h0);
    waitN(5);
    chk("pd_served", expQ.size(), 0);
    chk("rxei_p0", rxEi, 16'h0000);
    chk("rxei_p0_masked", rxEiM, 16'hFF00);
    txElecIdle = 16'h000F;
    waitN(2);
    chk("rxei_p0_partial", rxEi, 16'h000F);

    // Detect request in P0 is ignored
    txElecIdle = '1;
    txDetect   = 16'hFFFF;
    waitN(8);
    chk("detect_in_p0_idle", busy, 1'b0);
    txDetect = '0;
    waitN(1);

    // Detect and PowerDown change in the same cycle: detect wins
    c = cyc;
    powerDown = allLanes(P1);
    txDetect  = 16'hFFFF;
    pushExp(c + 4, detAll, detLow);
    waitN(6);
    chk("coincide_busy_wait", busy, 1'b1);
    txDetect = '0;
    pushExp(c + 9, 48'h0, 48'h0);
    waitN(6);
    chk("coincide_served", expQ.size(), 0);
    chk("coincide_idle", busy, 1'b0);

    // Rate change: handshake only when the feature is built
    c = cyc;
    rate = 4'd1;
`ifdef PIPE_RATE_CHANGE_EN
    pushExp(c + 8, 48'h0, 48'h0);
`endif
    waitN(12);
    chk("rate_served", expQ.size(), 0);
    chk("rate_idle", busy, 1'b0);

    // Detect request with lane-0 transmitter not idle is ignored
    txElecIdle = 16'hFFFE;
    txDetect   = 16'hFFFF;
    waitN(8);
    chk("detect_txactive_idle", busy, 1'b0);
    txDetect   = '0;
    txElecIdle = '1;
    waitN(1);

    // Reset during the second DETECT cycle aborts the request
    txDetect = 16'hFFFF;
    waitN(2);
    monOn    = 1'b0;
    reset    = 1'b1;
    txDetect = '0;
    waitN(1);
    chk("abort_phystatus", phyStatus, 16'hFFFF);
    chk("abort_rxstatus", rxStatus, 48'h0);
    chk("abort_rxei", rxEi, 16'hFFFF);
    chk("abort_busy", busy, 1'b1);
    reset = 1'b0;
    waitN(1);
    chk("abort_release_phystatus", phyStatus, 16'h0000);
    monOn = 1'b1;
    waitN(12);
    chk("abort_no_stale", expQ.size(), 0);
    chk("abort_idle", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
